fetch_ifid_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC and drives the synchronous instruction memory.
- Honours the hazard unit's ena_fetch/ena_ifid stall enables and ID-stage jump redirects.
- Delivers pc_IF/instr_IF/valid_IF to decode. A 1-entry skid buffer keeps the in-flight fetch from being lost during stalls.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_ifid_stage.sv | 126 ++++++++++++
 tb/tb_fetch_ifid_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I core: default widths, the reset PC, the bubble
// encoding, and the fetch-stage state encoding.
package rv_core_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, instr} holding register that catches the in-flight fetch
// while the stage is stalled. Clear takes priority over drain, and drain over load.
module fetch_skid_buf
    import rv_core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic            full
);

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            full_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (clr || drain) begin
            full_q <= 1'b0;
        end else if (load) begin
            full_q <= 1'b1;
        end
    end

    // Payload is meaningless while full_q is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end
    end

    assign pc    = pc_q;
    assign instr = instr_q;
    assign full  = full_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch plus the IF/ID register, with a one-entry skid for stalls.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_ifid_stage
    import rv_core_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena_fetch,
    input  logic            ena_ifid,
    input  logic            ena_jmp_pc,
    input  logic [XLEN-1:0] jmp_pc_ID,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_IF,
    output logic [31:0]     instr_IF,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic            valid_IF
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            req_live_q;

    logic            stall;
    logic            redirect;
    logic            skid_load;
    logic            skid_drain;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_full;

    assign stall      = !(ena_fetch && ena_ifid);
    assign redirect   = ena_jmp_pc && !stall;
    assign skid_load  = (state_q == RUN) && stall && req_live_q;
    assign skid_drain = (state_q == HOLD) && !stall && !redirect;
    assign imem_addr  = pc_q;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clr        (redirect),
        .load_pc    (req_pc_q),
        .load_instr (imem_rdata),
        .pc         (skid_pc),
        .instr      (skid_instr),
        .full       (skid_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            req_live_q <= 1'b0;
            pc_IF      <= '0;
            instr_IF   <= NOP_INSTR;
            valid_IF   <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                // Response to the current pc_q is stale; kill it and start at the target.
                pc_q       <= {jmp_pc_ID[XLEN-1:2], 2'b00};
                req_live_q <= 1'b0;
                instr_IF   <= NOP_INSTR;
                valid_IF   <= 1'b0;
                state_q    <= RUN;
            end else begin
                pc_q       <= pc_q + PC_STEP;
                req_pc_q   <= pc_q;
                req_live_q <= 1'b1;
                state_q    <= RUN;
                unique case (state_q)
                    BOOT: begin
                        instr_IF <= NOP_INSTR;
                        valid_IF <= 1'b0;
                    end
                    RUN: begin
                        pc_IF    <= req_pc_q;
                        instr_IF <= req_live_q ? imem_rdata : NOP_INSTR;
                        valid_IF <= req_live_q;
                    end
                    HOLD: begin
                        // Skid entry goes first; pc_q (held all stall) is re-issued now.
                        pc_IF    <= skid_pc;
                        instr_IF <= skid_instr;
                        valid_IF <= skid_full;
                    end
                    default: begin
                        instr_IF <= NOP_INSTR;
                        valid_IF <= 1'b0;
                    end
                endcase
            end
        end else if (state_q == RUN && req_live_q) begin
            state_q <= HOLD;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall)    stall_cnt <= sat_inc(stall_cnt);
            if (redirect) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: free run, stall/skid, redirect, wrap and reset.
// Build with FETCH_PERF_CNT_EN defined to also exercise the performance counters.
module tb_fetch_ifid_stage;
    import rv_core_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena_fetch;
    logic        ena_ifid;
    logic        ena_jmp_pc;
    logic [31:0] jmp_pc_ID;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IF;
    logic [31:0] instr_IF;
    logic        valid_IF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for last cycle's address.
    always @(posedge clk) imem_rdata <= imem_addr ^ KEY;

    fetch_ifid_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena_fetch  (ena_fetch),
        .ena_ifid   (ena_ifid),
        .ena_jmp_pc (ena_jmp_pc),
        .jmp_pc_ID  (jmp_pc_ID),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_IF      (pc_IF),
        .instr_IF   (instr_IF),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .valid_IF   (valid_IF)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        ena_fetch  = 1'b1;
        ena_ifid   = 1'b1;
        ena_jmp_pc = 1'b0;
        jmp_pc_ID  = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Leaves the stage with pc_IF = 8 held in IF/ID, pc_q = 16.
    task automatic run_to_pc8();
        apply_reset();
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ena_fetch  = 1'b1;
        ena_ifid   = 1'b1;
        ena_jmp_pc = 1'b0;
        jmp_pc_ID  = 32'h0;
        step();
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr: got %h want %h", imem_addr, 32'h0); end
        checks++; if (pc_IF !== 32'h0) begin errors++; $display("FAIL rst_pc_IF: got %h want %h", pc_IF, 32'h0); end
        checks++; if (instr_IF !== 32'h13) begin errors++; $display("FAIL rst_instr_IF: got %h want %h", instr_IF, 32'h13); end
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL rst_valid_IF: got %b want 0", valid_IF); end
        checks++; if (dut.state_q !== BOOT) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, BOOT); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        apply_reset();
        step();
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL run_boot_valid: got %b want 0", valid_IF); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL run_boot_addr: got %h want %h", imem_addr, 32'h4); end
        for (int i = 0; i < 6; i++) begin
            exp_pc = 32'(4 * i);
            step();
            checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL run_valid[%0d]: got %b want 1", i, valid_IF); end
            checks++; if (pc_IF !== exp_pc) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, pc_IF, exp_pc); end
            checks++; if (instr_IF !== (exp_pc ^ KEY)) begin errors++; $display("FAIL run_instr[%0d]: got %h want %h", i, instr_IF, exp_pc ^ KEY); end
            checks++; if (imem_addr !== exp_pc + 32'd8) begin errors++; $display("FAIL run_addr[%0d]: got %h want %h", i, imem_addr, exp_pc + 32'd8); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        run_to_pc8();
        ena_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_IF !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_IF, 32'h8); end
            checks++; if (instr_IF !== (32'h8 ^ KEY)) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr_IF, 32'h8 ^ KEY); end
            checks++; if (dut.state_q !== HOLD) begin errors++; $display("FAIL stall_state[%0d]: got %0d want %0d", i, dut.state_q, HOLD); end
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, 32'h10); end
        end
        ena_fetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(12 + 4 * i);
            step();
            checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL unstall_valid[%0d]: got %b want 1", i, valid_IF); end
            checks++; if (pc_IF !== exp_pc) begin errors++; $display("FAIL unstall_pc[%0d]: got %h want %h", i, pc_IF, exp_pc); end
            checks++; if (instr_IF !== (exp_pc ^ KEY)) begin errors++; $display("FAIL unstall_instr[%0d]: got %h want %h", i, instr_IF, exp_pc ^ KEY); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        run_to_pc8();
        ena_jmp_pc = 1'b1;
        jmp_pc_ID  = 32'h100;
        step();
        ena_jmp_pc = 1'b0;
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL jmp_bub1_valid: got %b want 0", valid_IF); end
        checks++; if (instr_IF !== 32'h13) begin errors++; $display("FAIL jmp_bub1_instr: got %h want %h", instr_IF, 32'h13); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jmp_addr: got %h want %h", imem_addr, 32'h100); end
        step();
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL jmp_bub2_valid: got %b want 0", valid_IF); end
        checks++; if (instr_IF !== 32'h13) begin errors++; $display("FAIL jmp_bub2_instr: got %h want %h", instr_IF, 32'h13); end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h100 + 32'(4 * i);
            step();
            checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL jmp_tgt_valid[%0d]: got %b want 1", i, valid_IF); end
            checks++; if (pc_IF !== exp_pc) begin errors++; $display("FAIL jmp_tgt_pc[%0d]: got %h want %h", i, pc_IF, exp_pc); end
            checks++; if (instr_IF !== (exp_pc ^ KEY)) begin errors++; $display("FAIL jmp_tgt_instr[%0d]: got %h want %h", i, instr_IF, exp_pc ^ KEY); end
        end
    endtask

    task automatic test_redirect_stall();
        run_to_pc8();
        ena_ifid   = 1'b0;
        ena_jmp_pc = 1'b1;
        jmp_pc_ID  = 32'h103;
        step();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL jstall_addr: got %h want %h", imem_addr, 32'h10); end
        checks++; if (pc_IF !== 32'h8) begin errors++; $display("FAIL jstall_pc: got %h want %h", pc_IF, 32'h8); end
        checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL jstall_valid: got %b want 1", valid_IF); end
        ena_ifid = 1'b1;
        step();
        ena_jmp_pc = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jrel_addr: got %h want %h", imem_addr, 32'h100); end
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL jrel_bub1: got %b want 0", valid_IF); end
        step();
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL jrel_bub2: got %b want 0", valid_IF); end
        step();
        checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL jrel_tgt_valid: got %b want 1", valid_IF); end
        checks++; if (pc_IF !== 32'h100) begin errors++; $display("FAIL jrel_tgt_pc: got %h want %h", pc_IF, 32'h100); end
        checks++; if (instr_IF !== (32'h100 ^ KEY)) begin errors++; $display("FAIL jrel_tgt_instr: got %h want %h", instr_IF, 32'h100 ^ KEY); end
    endtask

    task automatic test_reset_in_hold();
        run_to_pc8();
        ena_fetch = 1'b0;
        step();
        checks++; if (dut.state_q !== HOLD) begin errors++; $display("FAIL rh_pre_state: got %0d want %0d", dut.state_q, HOLD); end
        rst_n = 1'b0;
        step();
        checks++; if (pc_IF !== 32'h0) begin errors++; $display("FAIL rh_pc: got %h want %h", pc_IF, 32'h0); end
        checks++; if (instr_IF !== 32'h13) begin errors++; $display("FAIL rh_instr: got %h want %h", instr_IF, 32'h13); end
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b want 0", valid_IF); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rh_addr: got %h want %h", imem_addr, 32'h0); end
        checks++; if (dut.u_skid.full_q !== 1'b0) begin errors++; $display("FAIL rh_skid: got %b want 0", dut.u_skid.full_q); end
        checks++; if (dut.state_q !== BOOT) begin errors++; $display("FAIL rh_state: got %0d want %0d", dut.state_q, BOOT); end
        rst_n     = 1'b1;
        ena_fetch = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rh_boot_addr: got %h want %h", imem_addr, 32'h4); end
        step();
        checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL rh_first_valid: got %b want 1", valid_IF); end
        checks++; if (pc_IF !== 32'h0) begin errors++; $display("FAIL rh_first_pc: got %h want %h", pc_IF, 32'h0); end
        checks++; if (instr_IF !== KEY) begin errors++; $display("FAIL rh_first_instr: got %h want %h", instr_IF, KEY); end
    endtask

    task automatic test_wrap();
        run_to_pc8();
        ena_jmp_pc = 1'b1;
        jmp_pc_ID  = 32'hFFFF_FFFC;
        step();
        ena_jmp_pc = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'h0); end
        step();
        checks++; if (pc_IF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_top: got %h want %h", pc_IF, 32'hFFFF_FFFC); end
        checks++; if (instr_IF !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr_top: got %h want %h", instr_IF, 32'h5A5A_FFFC); end
        step();
        checks++; if (pc_IF !== 32'h0) begin errors++; $display("FAIL wrap_pc_zero: got %h want %h", pc_IF, 32'h0); end
        checks++; if (valid_IF !== 1'b1) begin errors++; $display("FAIL wrap_valid_zero: got %b want 1", valid_IF); end
    endtask

    task automatic test_boot_stall();
        apply_reset();
        ena_fetch = 1'b0;
        step();
        step();
        checks++; if (dut.state_q !== BOOT) begin errors++; $display("FAIL bstall_state: got %0d want %0d", dut.state_q, BOOT); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL bstall_addr: got %h want %h", imem_addr, 32'h0); end
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL bstall_valid: got %b want 0", valid_IF); end
        ena_fetch = 1'b1;
        step();
        step();
        checks++; if (pc_IF !== 32'h0 || valid_IF !== 1'b1) begin errors++; $display("FAIL bstall_first: got pc=%h v=%b want pc=0 v=1", pc_IF, valid_IF); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        apply_reset();
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL perf_rst: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        step();
        step();
        ena_fetch = 1'b0;
        repeat (5) step();
        ena_fetch  = 1'b1;
        jmp_pc_ID  = 32'h40;
        ena_jmp_pc = 1'b1;
        step();
        ena_jmp_pc = 1'b0;
        step();
        ena_jmp_pc = 1'b1;
        step();
        ena_jmp_pc = 1'b0;
        step();
        checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d want 5", stall_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d want 2", flush_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_in_hold();
        test_wrap();
        test_boot_stall();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
